// File: rtl/ps2_rx_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_rx_fifo_if : PS/2 pins plus the show-ahead byte read port       |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface ps2_rx_fifo_if #(
    parameter int DEPTH = 8
);
    logic                   ps2_clk;
    logic                   ps2_data;
    logic                   rd_en;
    logic                   err_clr;
    logic [7:0]             rd_data;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   parity_err;
    logic                   frame_err;
    logic                   overflow;

    modport slave (
        input  ps2_clk, ps2_data, rd_en, err_clr,
        output rd_data, empty, count, parity_err, frame_err, overflow
    );

    modport master (
        output ps2_clk, ps2_data, rd_en, err_clr,
        input  rd_data, empty, count, parity_err, frame_err, overflow
    );
endinterface
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_rx_fifo : checked PS/2 device-to-host receiver with byte FIFO   |
// | Optional parity checking: define PS2_RX_PARITY_EN.   Revision 1.0   |
// +--------------------------------------------------------------------+
module ps2_rx_fifo #(
    parameter int FILT_LEN = 8,
    parameter int DEPTH    = 8,
    parameter int TIMEOUT  = 100000
) (
    input  logic           clk,
    input  logic           reset,
    ps2_rx_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]          ps2c_sync_q, ps2d_sync_q;
    logic [FILT_LEN-1:0] hist_q;
    logic                filt_q, filt_d, fall_q;
    state_t              state_q, state_d;
    logic [2:0]          bitcnt_q, bitcnt_d;
    logic [7:0]          shreg_q, shreg_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                push, set_perr, set_ferr, data_bit;
`ifdef PS2_RX_PARITY_EN
    logic                par_q, par_d, perr_q;
`endif
    logic                ferr_q, ovf_q;
    logic [7:0]          mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q, count_w;
    logic                empty_w, full_w, do_pop, do_push, ovf_set;

    assign data_bit = ps2d_sync_q[1];

    // Filtered clock only moves after FILT_LEN agreeing samples.
    always_comb begin
        filt_d = filt_q;
        if (hist_q == '0)
            filt_d = 1'b0;
        else if (&hist_q)
            filt_d = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        tmo_d    = tmo_q;
        push     = 1'b0;
        set_perr = 1'b0;
        set_ferr = 1'b0;
`ifdef PS2_RX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (fall_q && !data_bit) begin
                    state_d  = DATA;
                    bitcnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall_q) begin
                    shreg_d  = {data_bit, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7)
                        state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall_q) begin
`ifdef PS2_RX_PARITY_EN
                    par_d = data_bit;
`endif
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall_q) begin
                    state_d  = IDLE;
                    set_ferr = !data_bit;
`ifdef PS2_RX_PARITY_EN
                    set_perr = !(^{shreg_q, par_q});
`endif
                    push     = !set_ferr && !set_perr;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE || fall_q) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TW'(TIMEOUT)) begin
                state_d  = IDLE;
                bitcnt_d = 3'd0;
                shreg_d  = 8'h00;
                tmo_d    = '0;
                set_ferr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2c_sync_q <= 2'b11;
            ps2d_sync_q <= 2'b11;
            hist_q      <= '1;
            filt_q      <= 1'b1;
            fall_q      <= 1'b0;
            state_q     <= IDLE;
            bitcnt_q    <= 3'd0;
            shreg_q     <= 8'h00;
            tmo_q       <= '0;
`ifdef PS2_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            ps2c_sync_q <= {ps2c_sync_q[0], bus.ps2_clk};
            ps2d_sync_q <= {ps2d_sync_q[0], bus.ps2_data};
            hist_q      <= {hist_q[FILT_LEN-2:0], ps2c_sync_q[1]};
            filt_q      <= filt_d;
            fall_q      <= filt_q && !filt_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            tmo_q       <= tmo_d;
`ifdef PS2_RX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count_w = wr_ptr_q - rd_ptr_q;
    assign empty_w = (count_w == '0);
    assign full_w  = (count_w == PW'(DEPTH));
    assign do_pop  = bus.rd_en && !empty_w;
    assign do_push = push && (!full_w || do_pop);
    assign ovf_set = push && full_w && !do_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 8'h00;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef PS2_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            ferr_q <= set_ferr || (ferr_q && !bus.err_clr);
            ovf_q  <= ovf_set  || (ovf_q  && !bus.err_clr);
`ifdef PS2_RX_PARITY_EN
            perr_q <= set_perr || (perr_q && !bus.err_clr);
`endif
        end
    end

    assign bus.rd_data    = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.empty      = empty_w;
    assign bus.count      = count_w;
    assign bus.frame_err  = ferr_q;
    assign bus.overflow   = ovf_q;
`ifdef PS2_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule
`default_nettype wire

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with a deglitched clock, full frame checking, an inter-bit timeout and a byte FIFO. It sits between the PS/2 connector pins and the keyboard scan-code decoder. It replaces the single-byte, unchecked receiver with checked frames, buffering, and sticky error reporting. The decoder pops bytes through a show-ahead read port.

## Interface
- FILT_LEN, 8: consecutive identical ps2_clk samples required to change the filtered clock level (≥2).
- DEPTH, 8: FIFO depth in bytes; power of two, ≥2.
- TIMEOUT, 100000: clk cycles allowed between falling edges inside a frame before abort.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_data  in  1  raw PS/2 data pin, asynchronous.
- rd_en  in  1  pop head byte; ignored when empty.
- rd_data  out  8  head byte, valid while empty=0.
- empty  out  1  FIFO empty.
- count  out  $clog2(DEPTH)+1  bytes held.
- err_clr  in  1  clears all sticky error flags.
- parity_err  out  1  sticky: a frame failed the odd-parity check.
- frame_err  out  1  sticky: bad stop bit or timeout abort.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.

## Operation
- ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Filter: the filtered clock goes low after FILT_LEN consecutive low samples and high after FILT_LEN consecutive high samples. Otherwise it holds its level. Its reset value is 1.
- A filtered high→low transition produces a one-cycle fall strobe. The synchronised data bit is sampled on that strobe.
- Frame format: start(0), D0..D7 LSB first, parity (odd over D0..D7 plus parity), stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a strobe with data=0, go to DATA and set bitcnt=0. On a strobe with data=1, stay in IDLE with no error (spurious edge).
  - DATA: on each strobe, shift the data bit into shreg[7] and shift right. After the 8th bit go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: on the strobe, return to IDLE and evaluate the frame.
- Frame evaluation:
  - stop=0: set frame_err and drop the byte.
  - Parity check failed (see Configuration): set parity_err and drop the byte.
  - Otherwise push the byte.
  - If both checks fail, set both flags.
- Timeout: a counter clears on every strobe and in IDLE, and increments in the other states. When it reaches TIMEOUT, the FSM returns to IDLE, sets frame_err, and discards the partial byte.
- FIFO: circular buffer, read and write pointers are $clog2(DEPTH)+1 bits wide, and all pointers wrap naturally.
  - rd_data is driven combinationally from mem[rd_ptr].
  - Push while full without a pop in the same cycle: the byte is dropped and overflow is set.
  - Push and pop in the same cycle: both execute, including when full. In that case count is unchanged and there is no overflow.
  - Pop while empty: no effect.
- Sticky flags: a set has priority over err_clr in the same cycle.
- Reset (asynchronous, at any point including mid-frame):
  - FSM goes to IDLE; shreg, bitcnt and timeout counter clear.
  - Filter history is all-ones and the filtered clock is 1.
  - Pointers clear and memory clears.
  - Output reset values: rd_data=0x00, empty=1, count=0, parity_err=0, frame_err=0, overflow=0.
  - A partial frame is lost. The receiver resynchronises on the next start bit.

## Timing
- Synchroniser latency: 2 cycles. Filter latency: FILT_LEN cycles after the pin settles.
- The fall strobe is registered: it is high in the cycle after the filtered clock goes low.
- Push occurs on the clk edge ending the STOP strobe cycle. empty=0, count and rd_data are updated in the following cycle. Error flags appear on the same edge as the push would have occurred.
- Pop: on the clk edge where rd_en=1 and empty=0, rd_ptr advances. The next byte (or empty=1) is visible immediately after that edge.
- Timeout abort: frame_err is set on the edge where the counter equals TIMEOUT. The FSM is in IDLE on that same edge.
- Throughput: one byte per frame. PS/2 frames at 10–16.7 kHz are far slower than clk, so the FIFO is the only point where data can be dropped.

## Configuration
- PS2_RX_PARITY_EN
  - Defined: parity is checked. A mismatching frame sets parity_err and the byte is not pushed.
  - Undefined: the parity bit is sampled and ignored. Bytes with a valid stop bit are always pushed, and parity_err is tied to 0.

## Test plan
- Clean frame for 0x1C (parity 0, stop 1) → empty deasserts, rd_data=0x1C, count=1. Then rd_en pulse → empty=1, count=0.
- Frame 0x1C with parity bit 1 and PS2_RX_PARITY_EN defined → parity_err=1, empty stays 1. With the macro undefined → 0x1C is pushed and parity_err stays 0.
- DEPTH+1 good frames (0x01..0x09 for DEPTH=8) with no reads → count=8, overflow=1, and reads return 0x01..0x08 in order. Also: push with simultaneous rd_en while full → no overflow, count stays 8.
- ps2_clk low glitches of FILT_LEN-1 cycles during idle and mid-frame → no strobe. A following clean frame 0xAA is received intact.
- Stop after 4 data bits for TIMEOUT+10 cycles → frame_err=1, FSM returns to IDLE, then a clean frame 0x55 is received. Also: err_clr pulse → all flags return to 0.
- Assert reset mid-frame after 5 bits → all outputs at reset values. The remainder of the interrupted frame is discarded (not pushed, or flagged frame_err). The next clean frame 0xF0 is received correctly.
